// File: rtl/add_sub_unit.sv
// Registered two's-complement add/subtract (M=0: A+B, M=1: A-B) with carry, overflow and zero flags.
// Latency 1 cycle, one op per cycle; no backpressure, out_valid is a one-cycle pulse per accepted op.
module add_sub_unit #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             M,
  output logic [WIDTH-1:0] S,
  output logic             C_final,
  output logic             V,
  output logic             Z,
  output logic             out_valid
);

  logic [WIDTH-1:0] s_d, s_q;
  logic             c_final_d, c_final_q;
  logic             v_d, v_q;
  logic             z_d, z_q;
  logic             out_valid_d, out_valid_q;

  logic [WIDTH-1:0] sum;
  logic             carry_out;
  logic             ovf;

  // Subtraction reuses the adder as A + ~B + 1: invert B and inject M as carry-in.
  always_comb begin
    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] bi;
    c    = '0;
    bi   = '0;
    sum  = '0;
    c[0] = M;
    for (int i = 0; i < WIDTH; i++) begin
      bi[i]  = B[i] ^ M;
      sum[i] = A[i] ^ bi[i] ^ c[i];
      c[i+1] = (A[i] & bi[i]) | (c[i] & (A[i] ^ bi[i]));
    end
    carry_out = c[WIDTH];
    ovf       = c[WIDTH] ^ c[WIDTH-1];
  end

  always_comb begin
    s_d         = s_q;
    c_final_d   = c_final_q;
    v_d         = v_q;
    z_d         = z_q;
    out_valid_d = in_valid;
    if (in_valid) begin
      s_d       = sum;
      c_final_d = carry_out;
      v_d       = ovf;
      z_d       = (sum == '0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_q         <= '0;
      c_final_q   <= 1'b0;
      v_q         <= 1'b0;
      z_q         <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      s_q         <= s_d;
      c_final_q   <= c_final_d;
      v_q         <= v_d;
      z_q         <= z_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign S         = s_q;
  assign C_final   = c_final_q;
  assign V         = v_q;
  assign Z         = z_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_add_sub_unit.sv
// Self-checking bench for add_sub_unit against an integer-arithmetic reference model.
// Checks directed, hold, back-to-back, random and asynchronous reset behaviour.
// Counts every comparison and every failing comparison; prints a summary.
`timescale 1ns/1ps
module tb_add_sub_unit;
    localparam int W = 4;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         M;
    logic [W-1:0] S;
    logic         C_final;
    logic         V;
    logic         Z;
    logic         out_valid;

    int tests_run = 0;
    int tests_failed = 0;

    logic [W+2:0] exp_r;
    logic         exp_ov;

    add_sub_unit #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .A(A), .B(B), .M(M),
        .S(S), .C_final(C_final), .V(V), .Z(Z), .out_valid(out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W+2:0] ref_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                               input logic m);
        int modv, ua, ub, sa, sb, r, s;
        logic c, v, z;
        modv = 1 << W;
        ua = int'(a);
        ub = int'(b);
        sa = (ua >= modv / 2) ? ua - modv : ua;
        sb = (ub >= modv / 2) ? ub - modv : ub;
        if (!m) begin
            s = (ua + ub) % modv;
            c = (ua + ub) >= modv;
            r = sa + sb;
        end else begin
            s = (ua - ub + modv) % modv;
            c = ua >= ub;
            r = sa - sb;
        end
        v = (r > modv / 2 - 1) || (r < -(modv / 2));
        z = (s == 0);
        return {s[W-1:0], c, v, z};
    endfunction

    task automatic drive(input logic vld, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic m);
        @(negedge clk);
        in_valid = vld;
        A = a;
        B = b;
        M = m;
    endtask

    task automatic test_reset;
        #1;
        tests_run++;
        if ({S, C_final, V, Z, out_valid} !== '0) begin
            tests_failed++;
            $display("FAIL reset_state: got S=%b C=%b V=%b Z=%b ov=%b, want all 0",
                     S, C_final, V, Z, out_valid);
        end
        @(negedge clk);
        rst = 1'b0;
        exp_r = '0;
        exp_ov = 1'b0;
    endtask

    task automatic test_directed;
        logic [W-1:0] ta [8] = '{4'b0001, 4'b0001, 4'b0011, 4'b1111, 4'b0111, 4'b1111, 4'b0101, 4'b0111};
        logic [W-1:0] tb [8] = '{4'b0000, 4'b0001, 4'b0011, 4'b1001, 4'b1001, 4'b0001, 4'b0101, 4'b0001};
        logic         tm [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [W+2:0] te [8] = '{{4'b0001, 3'b000}, {4'b0010, 3'b000}, {4'b0110, 3'b000},
                                 {4'b0110, 3'b100}, {4'b1110, 3'b010}, {4'b0000, 3'b101},
                                 {4'b0000, 3'b101}, {4'b1000, 3'b010}};
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, ta[i], tb[i], tm[i]);
            @(posedge clk);
            #1;
            tests_run++;
            if ({S, C_final, V, Z, out_valid} !== {te[i], 1'b1}) begin
                tests_failed++;
                $display("FAIL directed_%0d: got S=%b C=%b V=%b Z=%b ov=%b, want S=%b C=%b V=%b Z=%b ov=1",
                         i, S, C_final, V, Z, out_valid, te[i][W+2:3], te[i][2], te[i][1], te[i][0]);
            end
            exp_r = te[i];
        end
        exp_ov = 1'b1;
    endtask

    task automatic test_hold;
        drive(1'b0, 4'b1010, 4'b0101, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            tests_run++;
            if ({S, C_final, V, Z, out_valid} !== {exp_r, 1'b0}) begin
                tests_failed++;
                $display("FAIL hold_%0d: got S=%b C=%b V=%b Z=%b ov=%b, want %b ov=0",
                         i, S, C_final, V, Z, out_valid, exp_r);
            end
        end
        exp_ov = 1'b0;
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 100; i++) begin
            logic [W-1:0] a, b;
            logic m;
            a = W'($urandom);
            b = W'($urandom);
            m = 1'($urandom);
            drive(1'b1, a, b, m);
            @(posedge clk);
            #1;
            exp_r = ref_model(a, b, m);
            tests_run++;
            if ({S, C_final, V, Z, out_valid} !== {exp_r, 1'b1}) begin
                tests_failed++;
                $display("FAIL b2b_%0d: A=%b B=%b M=%b got S=%b C=%b V=%b Z=%b ov=%b, want %b ov=1",
                         i, a, b, m, S, C_final, V, Z, out_valid, exp_r);
            end
        end
    endtask

    task automatic test_random;
        for (int i = 0; i < 300; i++) begin
            logic [W-1:0] a, b;
            logic m, vld;
            a = W'($urandom);
            b = W'($urandom);
            m = 1'($urandom);
            vld = ($urandom_range(0, 3) != 0);
            drive(vld, a, b, m);
            @(posedge clk);
            #1;
            if (vld) exp_r = ref_model(a, b, m);
            exp_ov = vld;
            tests_run++;
            if ({S, C_final, V, Z, out_valid} !== {exp_r, exp_ov}) begin
                tests_failed++;
                $display("FAIL random_%0d: vld=%b A=%b B=%b M=%b got S=%b C=%b V=%b Z=%b ov=%b, want %b ov=%b",
                         i, vld, a, b, m, S, C_final, V, Z, out_valid, exp_r, exp_ov);
            end
        end
    endtask

    task automatic test_async_reset;
        drive(1'b1, 4'b0111, 4'b0001, 1'b0);
        @(posedge clk);
        #1;
        tests_run++;
        if ({S, C_final, V, Z, out_valid} !== {4'b1000, 3'b010, 1'b1}) begin
            tests_failed++;
            $display("FAIL pre_reset_op: got S=%b C=%b V=%b Z=%b ov=%b, want 1000 0 1 0 ov=1",
                     S, C_final, V, Z, out_valid);
        end
        #1;
        rst = 1'b1;
        #1;
        tests_run++;
        if ({S, C_final, V, Z, out_valid} !== '0) begin
            tests_failed++;
            $display("FAIL async_reset: got S=%b C=%b V=%b Z=%b ov=%b, want all 0",
                     S, C_final, V, Z, out_valid);
        end
        drive(1'b1, 4'b1111, 4'b0001, 1'b0);
        @(posedge clk);
        #1;
        tests_run++;
        if ({S, C_final, V, Z, out_valid} !== '0) begin
            tests_failed++;
            $display("FAIL op_during_reset: got S=%b C=%b V=%b Z=%b ov=%b, want all 0",
                     S, C_final, V, Z, out_valid);
        end
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        tests_run++;
        if ({S, C_final, V, Z, out_valid} !== '0) begin
            tests_failed++;
            $display("FAIL after_reset_idle: got S=%b C=%b V=%b Z=%b ov=%b, want all 0",
                     S, C_final, V, Z, out_valid);
        end
        drive(1'b1, 4'b0101, 4'b0101, 1'b1);
        @(posedge clk);
        #1;
        tests_run++;
        if ({S, C_final, V, Z, out_valid} !== {4'b0000, 3'b101, 1'b1}) begin
            tests_failed++;
            $display("FAIL first_after_reset: got S=%b C=%b V=%b Z=%b ov=%b, want 0000 1 0 1 ov=1",
                     S, C_final, V, Z, out_valid);
        end
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        A = '0;
        B = '0;
        M = 1'b0;
        test_reset();
        test_directed();
        test_hold();
        test_back_to_back();
        test_random();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
